game_sequencer: RTL
===================

// Module: game_sequencer
// PURPOSE
//  Top-level game FSM driving clear_redraw's state/curr_piece inputs on a 4x8 board (4-bit rows).
//  Sequences NEWBOARD -> GEN -> MOVE -> LAND, with repeated LAND passes until no full rows remain.
//  Picks pieces from an LFSR, paces gravity, keeps a line score, and detects game over from error_in.
// PARAMETERS
//  SETTLE      2      cycles per GEN/LAND pass before error_in/board_in are sampled (>=1)
//  DROP_TICKS  16     MOVE cycles per gravity pulse (>=2)
//  LFSR_SEED   8'hA5  LFSR reset value (non-zero)
// PORTS
//  clka        in   1   clock; all logic on posedge clka
//  restart     in   1   synchronous active-high reset
//  start       in   1   level; leaves NEWBOARD/GAMEOVER
//  landed      in   1   piece has landed (from move logic); sampled in MOVE only
//  error_in    in   1   spawn-collision flag from clear_redraw
//  board_in    in   32  current board from clear_redraw; row r = bits[4r+3:4r]
//  state       out  3   0=GEN 1=MOVE 2=LAND 4=NEWBOARD 5=GAMEOVER (registered)
//  curr_piece  out  2   piece type for the current spawn
//  drop_req    out  1   one-cycle gravity pulse
//  score       out  8   saturating count of full rows cleared
//  game_over   out  1   high while state==GAMEOVER
// BEHAVIOUR
//  Reset: state=4, curr_piece=0, drop_req=0, score=0, game_over=0, lfsr=LFSR_SEED,
//   pass counter=0, drop counter=0. Restart in any state applies next edge; no partial update.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every cycle incl. NEWBOARD.
//   Shift: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
//  NEWBOARD: score <= 0. If start=1 -> GEN.
//  GEN entry: curr_piece <= lfsr[1:0], latched on the edge that enters GEN.
//   curr_piece holds until the next GEN entry.
//  GEN: stays SETTLE cycles. On the last one, error_in=1 -> GAMEOVER, else -> MOVE.
//  MOVE entry: drop counter=0.
//   Counter increments each MOVE cycle; at DROP_TICKS-1, drop_req=1 for that cycle and counter wraps.
//   landed=1 -> LAND next edge. drop_req is forced 0 on any cycle with landed=1.
//  LAND pass: SETTLE cycles, pass counter reset at pass entry.
//   First cycle of the first pass: n = number of rows equal to 4'hF (0..8).
//   score <= min(score+n, 255), added once per landing, never on later passes.
//   At the end of the pass, if board_in still has any 4'hF row, start another LAND pass (state stays 2).
//   Otherwise -> GEN.
//   clear_redraw removes at most one row or one adjacent pair per pass, so multiple passes can be needed.
//  GAMEOVER: game_over=1. Board and score hold. start=1 -> NEWBOARD (score cleared there).
//  Simultaneous events: restart beats all. In MOVE, landed beats the drop pulse.
//   start is ignored outside NEWBOARD/GAMEOVER.
//  Illegal state codes (3,6,7) -> NEWBOARD next edge.
//  All outputs registered except drop_req and game_over, which decode registered state/counter.
// TESTING
//  1. restart 1 cycle, start=0 for 10 cycles -> state=4, score=0, drop_req=0, curr_piece=0 throughout.
//  2. start=1 at t0 -> state=0 at t0+1, curr_piece=LFSR_SEED-derived lfsr[1:0];
//     error_in=0 -> state=1 at t0+1+SETTLE.
//  3. MOVE, landed=0 for 40 cycles -> drop_req pulses at MOVE cycles 15 and 31, each exactly 1 cycle.
//  4. landed=1 with board_in=32'hFF00_000F (3 full rows) -> first pass adds 3;
//     second pass runs while a full row remains; score=3 and state returns to 0.
//  5. GEN with error_in=1 on last settle cycle -> state=5, game_over=1;
//     start=1 -> state=4, score=0; start again -> new GEN.
//  6. score=254, landing with 2 full rows -> score=255 (saturates).
//     restart asserted mid-MOVE -> next edge state=4, score=0, drop_req=0.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Handshake/bus bundle between the game sequencer and its surrounding game logic.
// The master side drives the game-status inputs; the slave side is the sequencer itself.
interface game_sequencer_if;
  logic        start;
  logic        landed;
  logic        error_in;
  logic [31:0] board_in;
  logic [2:0]  state;
  logic [1:0]  curr_piece;
  logic        drop_req;
  logic [7:0]  score;
  logic        game_over;

  modport master (
    output start, landed, error_in, board_in,
    input  state, curr_piece, drop_req, score, game_over
  );

  modport slave (
    input  start, landed, error_in, board_in,
    output state, curr_piece, drop_req, score, game_over
  );
endinterface

// File: rtl/game_sequencer.sv
// Top-level game FSM: NEWBOARD -> GEN -> MOVE -> LAND (repeated until no full rows) -> GEN.
// Picks pieces from an 8-bit LFSR, paces gravity, keeps a saturating line score.
module game_sequencer #(
  parameter int         SETTLE     = 2,
  parameter int         DROP_TICKS = 16,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic             clka,
  input  logic             restart,
  game_sequencer_if.slave  bus
);

  localparam int PW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int DW = $clog2(DROP_TICKS);

  typedef enum logic [2:0] {
    S_GEN      = 3'd0,
    S_MOVE     = 3'd1,
    S_LAND     = 3'd2,
    S_NEWBOARD = 3'd4,
    S_GAMEOVER = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      curr_piece_q, curr_piece_d;
  logic [7:0]      score_q, score_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [PW-1:0]   pass_cnt_q, pass_cnt_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            first_pass_q, first_pass_d;

  logic [3:0]      n_full;
  logic            any_full;
  logic            pass_last;
  logic            drop_last;
  logic [8:0]      score_sum;

  function automatic logic [3:0] count_full(input logic [31:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int r = 0; r < 8; r++)
      n = n + 4'(b[4*r +: 4] == 4'hF);
    return n;
  endfunction

  assign n_full    = count_full(bus.board_in);
  assign any_full  = (n_full != 4'd0);
  assign pass_last = (pass_cnt_q == PW'(SETTLE - 1));
  assign drop_last = (drop_cnt_q == DW'(DROP_TICKS - 1));
  assign score_sum = {1'b0, score_q} + 9'(n_full);

  always_comb begin
    state_d      = state_q;
    curr_piece_d = curr_piece_q;
    score_d      = score_q;
    pass_cnt_d   = pass_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    first_pass_d = first_pass_q;
    lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      S_NEWBOARD: begin
        score_d = 8'd0;
        if (bus.start) begin
          state_d      = S_GEN;
          pass_cnt_d   = '0;
          curr_piece_d = lfsr_q[1:0];
        end
      end

      S_GEN: begin
        if (pass_last) begin
          pass_cnt_d = '0;
          if (bus.error_in) begin
            state_d = S_GAMEOVER;
          end else begin
            state_d    = S_MOVE;
            drop_cnt_d = '0;
          end
        end else begin
          pass_cnt_d = pass_cnt_q + PW'(1);
        end
      end

      S_MOVE: begin
        // landed wins over the gravity tick; the counter is restarted on the next MOVE entry
        if (bus.landed) begin
          state_d      = S_LAND;
          pass_cnt_d   = '0;
          first_pass_d = 1'b1;
        end else begin
          drop_cnt_d = drop_last ? '0 : drop_cnt_q + DW'(1);
        end
      end

      S_LAND: begin
        if (first_pass_q && pass_cnt_q == '0)
          score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
        if (pass_last) begin
          pass_cnt_d   = '0;
          first_pass_d = 1'b0;
          if (!any_full) begin
            state_d      = S_GEN;
            curr_piece_d = lfsr_q[1:0];
          end
        end else begin
          pass_cnt_d = pass_cnt_q + PW'(1);
        end
      end

      S_GAMEOVER: begin
        if (bus.start) state_d = S_NEWBOARD;
      end

      default: state_d = S_NEWBOARD;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q      <= S_NEWBOARD;
      curr_piece_q <= 2'd0;
      score_q      <= 8'd0;
      lfsr_q       <= LFSR_SEED;
      pass_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      first_pass_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      curr_piece_q <= curr_piece_d;
      score_q      <= score_d;
      lfsr_q       <= lfsr_d;
      pass_cnt_q   <= pass_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      first_pass_q <= first_pass_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.curr_piece = curr_piece_q;
  assign bus.score      = score_q;
  assign bus.drop_req   = (state_q == S_MOVE) && drop_last && !bus.landed;
  assign bus.game_over  = (state_q == S_GAMEOVER);

endmodule
